// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: FSM states and sizing helpers.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int WIDTH_DEF = 32;
    localparam int STEP_DEF  = 1;
    localparam int ITER      = WIDTH_DEF / STEP_DEF;

    function automatic int iter_count(input int width, input int step);
        return width / step;
    endfunction

    // Counter must hold the full iteration count, hence ITER+1 states.
    function automatic int cnt_width(input int iter);
        return $clog2(iter + 1);
    endfunction

endpackage

// File: rtl/mul_iter_if.sv
// Request/response bundle between the control unit and the iterative multiplier.
interface mul_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, a, b,
        input  ready, busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, a, b,
        output ready, busy, done, hi, lo
    );
endinterface

// File: rtl/mul_iter_step.sv
// Combinational STEP-bit partial product of mcand, added onto the running accumulator.
module mul_iter_step #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [STEP-1:0]    digit,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [2*WIDTH-1:0] terms [STEP];

    genvar gi;
    generate
        for (gi = 0; gi < STEP; gi++) begin : g_term
            assign terms[gi] = digit[gi] ? (mcand << gi) : '0;
        end
    endgenerate

    always_comb begin
        acc_next = acc;
        for (int i = 0; i < STEP; i++) begin
            acc_next = acc_next + terms[i];
        end
    end

endmodule

// File: rtl/mul_iter.sv
// Multi-cycle signed/unsigned shift-add multiplier retiring STEP multiplier bits per cycle.
// Optional MUL_ITER_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier is zero.
module mul_iter
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,   // even, >= 4
    parameter int STEP  = 1     // 1, 2, 4 or 8, divides WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    mul_iter_if.slave  bus
);

    localparam int N_ITER = iter_count(WIDTH, STEP);
    localparam int CNT_W  = cnt_width(N_ITER);

    state_t             state_reg;
    state_t             state_next;
    logic               ready_c;
    logic               busy_c;
    logic               done_c;
    logic               accept;
    logic               run_last;

    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               neg_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod_fin;

    assign accept = bus.start & ready_c;

    // |most-negative| still fits as an unsigned WIDTH-bit magnitude.
    assign mag_a = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // The RUN cycle after the last retirement only decides the exit.
`ifdef MUL_ITER_EARLY_TERM_EN
    assign run_last = (cnt_reg == '0) || (mplier_reg == '0);
`else
    assign run_last = (cnt_reg == '0);
`endif

    assign prod_fin = neg_reg ? -acc_reg : acc_reg;

    mul_iter_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .acc      (acc_reg),
        .mcand    (mcand_reg),
        .digit    (mplier_reg[STEP-1:0]),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready_c    = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (run_last) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                busy_c     = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                ready_c    = 1'b1;
                done_c     = 1'b1;
                state_next = bus.start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            if (accept) begin
                acc_reg    <= '0;
                mcand_reg  <= {{WIDTH{1'b0}}, mag_a};
                mplier_reg <= mag_b;
                cnt_reg    <= CNT_W'(N_ITER);
                neg_reg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            end else if (state_reg == RUN && !run_last) begin
                acc_reg    <= acc_next;
                mcand_reg  <= mcand_reg << STEP;
                mplier_reg <= mplier_reg >> STEP;
                cnt_reg    <= cnt_reg - CNT_W'(1);
            end
            if (state_reg == FIN) begin
                {hi_reg, lo_reg} <= prod_fin;
            end
        end
    end

    assign bus.ready = ready_c;
    assign bus.busy  = busy_c;
    assign bus.done  = done_c;
    assign bus.hi    = hi_reg;
    assign bus.lo    = lo_reg;

endmodule

// File: tb/tb_mul_iter.sv
// Bench for mul_iter: four instances (STEP=1,2,4,8) driven in lockstep, checked against directed
// constants and a 64-bit reference product.
module tb_mul_iter;
    import mul_pkg::*;

    localparam int W  = 32;
    localparam int ND = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;

    logic [ND-1:0]  done_v;
    logic [ND-1:0]  ready_v;
    logic [ND-1:0]  busy_v;
    logic [2*W-1:0] prod_v [ND];
    logic [2*W-1:0] prev_v [ND];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < ND; gi++) begin : g_dut
            mul_iter_if #(.WIDTH(W)) bus ();
            assign bus.start     = start;
            assign bus.is_signed = sgn;
            assign bus.a         = a_in;
            assign bus.b         = b_in;
            mul_iter #(.WIDTH(W), .STEP(1 << gi)) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );
            assign done_v[gi]  = bus.done;
            assign ready_v[gi] = bus.ready;
            assign busy_v[gi]  = bus.busy;
            assign prod_v[gi]  = {bus.hi, bus.lo};
        end
    endgenerate

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] px;
        logic [63:0] py;
        px = s ? {{32{x[31]}}, x} : {32'b0, x};
        py = s ? {{32{y[31]}}, y} : {32'b0, y};
        return px * py;
    endfunction

    function automatic int exp_lat(input int step, input logic s, input logic [31:0] y);
        logic [31:0] m;
        int          it;
        m  = (s && y[31]) ? -y : y;
        it = 0;
        for (int i = 0; i < W / step; i++) begin
`ifdef MUL_ITER_EARLY_TERM_EN
            if (m == '0) break;
`endif
            m = m >> step;
            it++;
        end
        return it + 2;
    endfunction

    task automatic launch(input logic s, input logic [31:0] x, input logic [31:0] y, input int hold);
        @(negedge clk);
        check("ready_before_accept", 64'(ready_v), 64'hF);
        start = 1'b1;
        sgn   = s;
        a_in  = x;
        b_in  = y;
        @(posedge clk);
        #1;
        if (hold == 0) start = 1'b0;
        sgn  = 1'($urandom);
        a_in = $urandom;
        b_in = $urandom;
    endtask

    // Called just after the accepting edge; optionally issues the next start in the DONE cycle.
    task automatic wait_result(input string tag, input logic s, input logic [31:0] y,
                               input logic [63:0] exp, input int hold, input bit chain,
                               input logic cs, input logic [31:0] cx, input logic [31:0] cy);
        int lat [ND];
        int seen [ND];
        int pulses [ND];
        int busy_bad;
        int hold_bad;
        int maxlat;
        maxlat   = 0;
        busy_bad = 0;
        hold_bad = 0;
        for (int d = 0; d < ND; d++) begin
            lat[d]    = exp_lat(1 << d, s, y);
            seen[d]   = 0;
            pulses[d] = 0;
            if (lat[d] > maxlat) maxlat = lat[d];
        end
        for (int k = 1; k <= maxlat; k++) begin
            @(posedge clk);
            #1;
            if (k == hold) start = 1'b0;
            for (int d = 0; d < ND; d++) begin
                if (done_v[d]) begin
                    pulses[d]++;
                    if (seen[d] == 0) seen[d] = k;
                    check($sformatf("%s_prod_s%0d", tag, 1 << d), prod_v[d], exp);
                end else if (k < lat[d] && prod_v[d] !== prev_v[d]) begin
                    hold_bad++;
                end
            end
            if (k < lat[0] && !busy_v[0]) busy_bad++;
        end
        for (int d = 0; d < ND; d++) begin
            check($sformatf("%s_lat_s%0d", tag, 1 << d), 64'(seen[d]), 64'(lat[d]));
            check($sformatf("%s_pulses_s%0d", tag, 1 << d), 64'(pulses[d]), 64'd1);
            prev_v[d] = exp;
        end
        check({tag, "_busy"}, 64'(busy_bad), 64'd0);
        check({tag, "_hilo_hold"}, 64'(hold_bad), 64'd0);
        $display("op %s sgn=%0d b=%h prod=%h exp=%h lat=%0d", tag, s, y, prod_v[0], exp, seen[0]);
        if (chain) begin
            check({tag, "_ready_in_done"}, 64'(ready_v), 64'hF);
            start = 1'b1;
            sgn   = cs;
            a_in  = cx;
            b_in  = cy;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp);
        launch(s, x, y, 0);
        wait_result(tag, s, y, exp, 0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic reset_midop();
        int late;
        launch(1'b0, 32'h1234_5678, 32'h8765_4321, 0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", 64'(ready_v), 64'hF);
        check("rst_busy", 64'(busy_v), 64'h0);
        check("rst_done", 64'(done_v), 64'h0);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("rst_hilo_s%0d", 1 << d), prod_v[d], 64'h0);
            prev_v[d] = '0;
        end
        rst  = 1'b0;
        late = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_v != '0) late++;
        end
        check("rst_no_done", 64'(late), 64'd0);
        $display("op reset_midop aborted, late_done=%0d", late);
    endtask

    initial begin
        logic        rs;
        logic [31:0] rx;
        logic [31:0] ry;
        for (int d = 0; d < ND; d++) prev_v[d] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready_v), 64'hF);
        check("reset_busy", 64'(busy_v), 64'h0);
        check("reset_done", 64'(done_v), 64'h0);
        check("reset_hilo", prod_v[0], 64'h0);
        rst = 1'b0;

        run_op("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("neg3x7", 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB);

        // start left high (with changing operands) through the early RUN cycles
        launch(1'b1, 32'h8000_0000, 32'h8000_0000, 4);
        wait_result("minsq_hold", 1'b1, 32'h8000_0000, 64'h4000_0000_0000_0000, 4, 1'b0, 1'b0, '0, '0);

        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        wait_result("pre_b2b", 1'b0, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 1'b1,
                    1'b0, 32'd5, 32'd6);
        wait_result("b2b", 1'b0, 32'd6, 64'd30, 0, 1'b0, 1'b0, '0, '0);

        run_op("bzero", 1'b0, 32'h0001_2345, 32'h0000_0000, 64'h0);
        run_op("bone", 1'b1, 32'hABCD_EF01, 32'h0000_0001, 64'hFFFF_FFFF_ABCD_EF01);
        run_op("sneg_neg", 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 64'h0000_0000_8000_0000);

        reset_midop();

        for (int i = 0; i < 1000; i++) begin
            rs = 1'($urandom);
            rx = $urandom;
            ry = $urandom;
            if (i % 50 == 0) ry = ry >> (i % 32);
            launch(rs, rx, ry, 0);
            wait_result($sformatf("rnd%0d", i), rs, ry, ref_prod(rs, rx, ry), 0, 1'b0, 1'b0, '0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
